// File: rtl/vec_mem_reader.sv
// vec_mem_reader: reads numVecs consecutive vectors from data memory and streams them out
// as bytes over valid/ready. Define VMR_CHECKSUM_EN to append an XOR checksum byte.
module vec_mem_reader #(
  parameter int regSize  = 16,
  parameter int vecSize  = 4,
  parameter int addrBits = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [addrBits-1:0]         baseAddr,
  input  logic [addrBits:0]           numVecs,
  output logic                        memRdEn,
  output logic [addrBits-1:0]         memAddr,
  input  logic [vecSize*regSize-1:0]  memRdData,
  output logic [7:0]                  outData,
  output logic                        outValid,
  input  logic                        outReady,
  output logic                        busy,
  output logic                        done
);

  localparam int vecBits  = vecSize * regSize;
  localparam int numBytes = vecBits / 8;
  localparam int cntBits  = $clog2(numBytes + 1);

  localparam logic [cntBits-1:0]  byteInit = cntBits'(numBytes);
  localparam logic [cntBits-1:0]  byteOne  = cntBits'(1);
  localparam logic [addrBits:0]   vecOne   = (addrBits + 1)'(1);
  localparam logic [addrBits-1:0] addrOne  = addrBits'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
`ifdef VMR_CHECKSUM_EN
    CSUM = 3'd4,
`endif
    DONE = 3'd5
  } stateT;

  stateT                state, stateNext;
  logic [addrBits-1:0]  addr, addrNext;
  logic [addrBits:0]    vecCnt, vecCntNext;
  logic [cntBits-1:0]   byteCnt, byteCntNext;
  logic [vecBits-1:0]   shiftReg, shiftNext;
  logic [addrBits-1:0]  memAddrNext;
  logic [7:0]           outDataNext;
  logic                 handshake;

`ifdef VMR_CHECKSUM_EN
  logic [7:0] csum, csumNext;

  function automatic logic [7:0] xorFold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  assign handshake = outValid && outReady;

  // Next-state, datapath and next-output decode
  always_comb begin
    stateNext   = state;
    addrNext    = addr;
    vecCntNext  = vecCnt;
    byteCntNext = byteCnt;
    shiftNext   = shiftReg;
`ifdef VMR_CHECKSUM_EN
    csumNext    = csum;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          addrNext   = baseAddr;
          vecCntNext = numVecs;
`ifdef VMR_CHECKSUM_EN
          csumNext   = 8'h00;
`endif
          stateNext  = (numVecs == '0) ? DONE : READ;
        end else begin
          stateNext = IDLE;
        end
      end
      READ: stateNext = WAIT;
      WAIT: begin
        shiftNext   = memRdData;
        byteCntNext = byteInit;
        stateNext   = SEND;
      end
      SEND: begin
        if (handshake) begin
`ifdef VMR_CHECKSUM_EN
          csumNext    = xorFold(csum, shiftReg[7:0]);
`endif
          shiftNext   = shiftReg >> 8;
          byteCntNext = byteCnt - byteOne;
          if (byteCnt == byteOne) begin
            addrNext   = addr + addrOne;
            vecCntNext = vecCnt - vecOne;
            if (vecCnt != vecOne) begin
              stateNext = READ;
            end else begin
`ifdef VMR_CHECKSUM_EN
              stateNext = CSUM;
`else
              stateNext = DONE;
`endif
            end
          end else begin
            stateNext = SEND;
          end
        end else begin
          stateNext = SEND;
        end
      end
`ifdef VMR_CHECKSUM_EN
      CSUM: begin
        if (handshake) begin
          stateNext = DONE;
        end else begin
          stateNext = CSUM;
        end
      end
`endif
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered
    memAddrNext = (stateNext == READ) ? addrNext : '0;
    case (stateNext)
      SEND:    outDataNext = shiftNext[7:0];
`ifdef VMR_CHECKSUM_EN
      CSUM:    outDataNext = csumNext;
`endif
      default: outDataNext = 8'h00;
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      addr     <= '0;
      vecCnt   <= '0;
      byteCnt  <= '0;
      shiftReg <= '0;
`ifdef VMR_CHECKSUM_EN
      csum     <= 8'h00;
`endif
      memRdEn  <= 1'b0;
      memAddr  <= '0;
      outData  <= 8'h00;
      outValid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= stateNext;
      addr     <= addrNext;
      vecCnt   <= vecCntNext;
      byteCnt  <= byteCntNext;
      shiftReg <= shiftNext;
`ifdef VMR_CHECKSUM_EN
      csum     <= csumNext;
      outValid <= (stateNext == SEND) || (stateNext == CSUM);
`else
      outValid <= (stateNext == SEND);
`endif
      memRdEn  <= (stateNext == READ);
      memAddr  <= memAddrNext;
      outData  <= outDataNext;
      busy     <= (stateNext != IDLE);
      done     <= (stateNext == DONE);
    end
  end

endmodule

// File: tb/tb_vec_mem_reader.sv
// tb_vec_mem_reader: table-driven dump checks plus hand sequences for reset and abort.
module tb_vec_mem_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  baseAddr;
  logic [8:0]  numVecs;
  logic        memRdEn;
  logic [7:0]  memAddr;
  logic [63:0] memRdData;
  logic [7:0]  outData;
  logic        outValid;
  logic        outReady;
  logic        busy;
  logic        done;

  logic [63:0] mem [256];
  int nVec = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  vec_mem_reader dut (
    .clk(clk), .rst(rst), .start(start), .baseAddr(baseAddr), .numVecs(numVecs),
    .memRdEn(memRdEn), .memAddr(memAddr), .memRdData(memRdData),
    .outData(outData), .outValid(outValid), .outReady(outReady),
    .busy(busy), .done(done)
  );

  // Data memory with a registered read port
  always_ff @(posedge clk) begin
    if (memRdEn) memRdData <= mem[memAddr];
  end

  typedef struct {
    logic [7:0]   base;
    logic [8:0]   num;
    int           mode;          // 0: ready always, 1: ready pattern 1,0,0
    bit           midStart;      // pulse a stray start while busy
    int           expN;          // data bytes
    logic [127:0] expBytes;      // byte i at [i*8 +: 8]
    int           expRd;
    logic [7:0]   expAddr0;
    logic [7:0]   expAddrL;
    int           expFirstValid;
    int           expLastCyc;    // cycle of last data-byte handshake, -1 to skip
    logic [7:0]   expXor;
  } recT;

  recT tbl [5];

  logic [7:0] got [$];
  int         gotCyc [$];
  logic [7:0] addrs [$];
  int doneCnt, busyCnt, firstValid, firstRd, doneCyc;
  bit finished;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic runDump(input recT r);
    bit stalled;
    logic [7:0] prevData;
    got.delete(); gotCyc.delete(); addrs.delete();
    doneCnt = 0; busyCnt = 0; firstValid = -1; firstRd = -1; doneCyc = -1;
    finished = 1'b0; stalled = 1'b0; prevData = 8'h00;
    @(negedge clk);
    baseAddr = r.base; numVecs = r.num; start = 1'b1; outReady = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (stalled) begin
        check("stallValid", outValid, 1'b1);
        check("stallData", outData, prevData);
      end
      if (memRdEn) begin
        addrs.push_back(memAddr);
        if (firstRd < 0) firstRd = cyc;
      end
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        doneCyc = cyc;
      end
      outReady = (r.mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (outValid && firstValid < 0) firstValid = cyc;
      if (outValid && outReady) begin
        got.push_back(outData);
        gotCyc.push_back(cyc);
      end
      stalled  = outValid && !outReady;
      prevData = outData;
      if (r.midStart && cyc == 4) begin
        start = 1'b1; baseAddr = 8'h55; numVecs = 9'd3;
      end
      if (doneCnt > 0 && !busy) begin
        finished = 1'b1;
        break;
      end
    end
    outReady = 1'b0;
  endtask

  task automatic checkRec(input int idx);
    recT r;
    int totalN;
    r = tbl[idx];
    runDump(r);
    totalN = r.expN;
`ifdef VMR_CHECKSUM_EN
    if (r.expN > 0) totalN = r.expN + 1;
`endif
    check("finished", finished, 1'b1);
    check("byteCount", got.size(), totalN);
    for (int i = 0; i < r.expN && i < got.size(); i++)
      check("byte", got[i], r.expBytes[i*8 +: 8]);
`ifdef VMR_CHECKSUM_EN
    if (got.size() > r.expN && r.expN > 0) check("checksum", got[r.expN], r.expXor);
`endif
    check("rdCount", addrs.size(), r.expRd);
    if (r.expRd > 0 && addrs.size() > 0) begin
      check("firstRdCyc", firstRd, 1);
      check("addrFirst", addrs[0], r.expAddr0);
      check("addrLast", addrs[addrs.size()-1], r.expAddrL);
    end
    check("doneCount", doneCnt, 1);
    check("firstValid", firstValid, r.expFirstValid);
    if (r.expLastCyc > 0 && r.expN > 0 && gotCyc.size() >= r.expN)
      check("lastByteCyc", gotCyc[r.expN-1], r.expLastCyc);
    if (r.expN == 0) begin
      check("zeroDoneCyc", doneCyc, 1);
      check("zeroBusyCycles", busyCnt, 1);
    end
  endtask

  initial begin
    int hs;
    int lateDone;
    int lateValid;
    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
    mem[8'h10] = 64'hDDDD_CCCC_BBBB_1234;
    mem[8'hFF] = 64'h0807_0605_0403_0201;
    mem[8'h00] = 64'h100F_0E0D_0C0B_0A09;
    mem[8'h20] = 64'hA1A2_A3A4_A5A6_A7A8;
    mem[8'h21] = 64'hB1B2_B3B4_B5B6_B7B8;
    mem[8'h22] = 64'hC1C2_C3C4_C5C6_C7C8;
    mem[8'h23] = 64'hD1D2_D3D4_D5D6_D7D8;
    memRdData = 64'h0;

    tbl[0] = '{8'h10, 9'd1, 0, 1'b0, 8, 128'h0000_0000_0000_0000_DDDD_CCCC_BBBB_1234,
               1, 8'h10, 8'h10, 3, 10, 8'h26};
    tbl[1] = '{8'h10, 9'd1, 1, 1'b0, 8, 128'h0000_0000_0000_0000_DDDD_CCCC_BBBB_1234,
               1, 8'h10, 8'h10, 3, -1, 8'h26};
    tbl[2] = '{8'hFF, 9'd2, 0, 1'b0, 16, 128'h100F_0E0D_0C0B_0A09_0807_0605_0403_0201,
               2, 8'hFF, 8'h00, 3, 20, 8'h10};
    tbl[3] = '{8'h40, 9'd0, 0, 1'b0, 0, 128'h0, 0, 8'h00, 8'h00, -1, -1, 8'h00};
    tbl[4] = '{8'h10, 9'd1, 0, 1'b1, 8, 128'h0000_0000_0000_0000_DDDD_CCCC_BBBB_1234,
               1, 8'h10, 8'h10, 3, 10, 8'h26};

    rst = 1'b0; start = 1'b0; baseAddr = 8'h00; numVecs = 9'd0; outReady = 1'b0;
    repeat (2) @(negedge clk);
    check("rstMemRdEn", memRdEn, 1'b0);
    check("rstMemAddr", memAddr, 8'h00);
    check("rstOutData", outData, 8'h00);
    check("rstOutValid", outValid, 1'b0);
    check("rstBusy", busy, 1'b0);
    check("rstDone", done, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      checkRec(t);
      repeat (2) @(negedge clk);
    end

    // Abort with reset while the third byte of a four-vector dump is on the bus
    @(negedge clk);
    baseAddr = 8'h20; numVecs = 9'd4; start = 1'b1; outReady = 1'b1;
    hs = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (outValid && outReady) hs++;
      if (hs == 3) break;
    end
    check("abortSetup", hs, 3);
    check("abortThirdByte", outData, 8'hA6);
    rst = 1'b0;
    @(negedge clk);
    check("abortOutValid", outValid, 1'b0);
    check("abortBusy", busy, 1'b0);
    check("abortDone", done, 1'b0);
    check("abortMemRdEn", memRdEn, 1'b0);
    rst = 1'b1;
    lateDone = 0; lateValid = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (done) lateDone++;
      if (outValid) lateValid++;
    end
    check("abortNoDone", lateDone, 0);
    check("abortIdleValid", lateValid, 0);
    checkRec(0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
